unit_prop_ctrl: RTL and testbench

//  Sequences unit propagation around the unitClause finder and a formula simplifier.

---
 rtl/unit_prop_if.sv | 43 ++++
 rtl/unit_prop_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_unit_prop_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unit_prop_if.sv
// unit_prop_if
//  Bundles the two request/response handshakes between the unit propagation
//  controller and its finder/simplifier pair.
//
//  Handshake semantics (both channels): the controller raises a one-cycle
//  request pulse (uc_find / simp_start). The responder later raises a
//  one-cycle completion pulse (uc_ended / simp_done). Its qualifiers
//  (uc_found, uc_lit / simp_conflict) are valid only in that completion
//  cycle. simp_lit is held stable from simp_start until simp_done.
//  Completion pulses arriving when the controller is not waiting are dropped.
//
//  Signals
//   uc_find        ctrl -> finder      request pulse
//   uc_ended       finder -> ctrl      completion pulse
//   uc_found       finder -> ctrl      unit clause found (with uc_ended)
//   uc_lit         finder -> ctrl      unit literal (with uc_ended & uc_found)
//   simp_start     ctrl -> simplifier  request pulse
//   simp_lit       ctrl -> simplifier  literal to apply
//   simp_done      simplifier -> ctrl  completion pulse
//   simp_conflict  simplifier -> ctrl  empty clause produced (with simp_done)
//  Modports: master = controller side, slave = finder/simplifier side.
interface unit_prop_if #(
  parameter int LIT_W = 6
);
  logic             uc_find;
  logic             uc_ended;
  logic             uc_found;
  logic [LIT_W-1:0] uc_lit;
  logic             simp_start;
  logic [LIT_W-1:0] simp_lit;
  logic             simp_done;
  logic             simp_conflict;

  modport master (
    output uc_find, simp_start, simp_lit,
    input  uc_ended, uc_found, uc_lit, simp_done, simp_conflict
  );

  modport slave (
    input  uc_find, simp_start, simp_lit,
    output uc_ended, uc_found, uc_lit, simp_done, simp_conflict
  );
endinterface

// File: rtl/unit_prop_ctrl.sv
// unit_prop_ctrl
//  Sequences unit propagation: pulses the unit clause finder, records each
//  returned literal in an assignment map, hands the literal to the formula
//  simplifier, and loops until no unit remains, a conflict occurs, a literal
//  repeats or is malformed, the run is aborted, or a watchdog expires.
//
//  Ports
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          begin a run (IDLE only)
//   abort          abandon the current run (any active state)
//   clear_map      zero the assignment map (IDLE only, start has priority)
//   busy           high in every state except IDLE
//   done           one-cycle pulse when a run ends, result valid with it
//   result         0 FIXPOINT, 1 CONFLICT, 2 REPEAT, 3 TIMEOUT, 4 ABORT, 5 BADLIT
//   prop_count     literals applied this run, saturating
//   assign_set     bit v-1 set = variable v assigned
//   assign_val     bit v-1 = value of variable v where assigned
//   fsm_state      current FSM state for observation
//   bus            finder/simplifier handshakes (master side)
//
//  Literal format: bit LIT_W-1 is the negation flag, bits LIT_W-2:0 hold the
//  variable index (1..NUM_VARS, 0 is invalid). All outputs are registered;
//  each is computed from the next state so it lines up with the state it
//  belongs to.
module unit_prop_ctrl #(
  parameter int NUM_VARS = 16,
  parameter int LIT_W    = 6,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                clear_map,
  output logic                busy,
  output logic                done,
  output logic [2:0]          result,
  output logic [CNT_W-1:0]    prop_count,
  output logic [NUM_VARS-1:0] assign_set,
  output logic [NUM_VARS-1:0] assign_val,
  output logic [2:0]          fsm_state,
  unit_prop_if.master         bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FIND      = 3'd1;
  localparam logic [2:0] S_WAIT_UC   = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_SIMP      = 3'd4;
  localparam logic [2:0] S_WAIT_SIMP = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  localparam logic [2:0] R_FIXPOINT = 3'd0;
  localparam logic [2:0] R_CONFLICT = 3'd1;
  localparam logic [2:0] R_REPEAT   = 3'd2;
  localparam logic [2:0] R_TIMEOUT  = 3'd3;
  localparam logic [2:0] R_ABORT    = 3'd4;
  localparam logic [2:0] R_BADLIT   = 3'd5;

  // One spare bit so TIMEOUT itself is representable.
  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic [2:0]          next_result;
  logic [WD_W-1:0]     watchdog;
  logic [LIT_W-1:0]    lit_q;

  logic [31:0]         var_num;
  logic                lit_bad;
  logic                lit_value;
  logic [NUM_VARS-1:0] var_mask;
  logic                var_assigned;
  logic                var_value;
  logic                wd_expired;
  logic                apply_lit;

  assign fsm_state = state;

  // Decode of the latched literal, used in CHECK.
  assign var_num      = 32'(lit_q[LIT_W-2:0]);
  assign lit_bad      = (var_num == 32'd0) || (var_num > 32'(NUM_VARS));
  assign lit_value    = ~lit_q[LIT_W-1];
  // For a bad index the shift leaves the mask zero; it is never used then.
  assign var_mask     = NUM_VARS'(1) << (var_num - 32'd1);
  assign var_assigned = |(assign_set & var_mask);
  assign var_value    = |(assign_val & var_mask);
  assign wd_expired   = (watchdog == WD_LAST);
  assign apply_lit    = (state == S_CHECK) && (next_state == S_SIMP);

  always_comb begin
    next_state  = state;
    next_result = result;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_FIND;
      end
      S_FIND: next_state = S_WAIT_UC;
      S_WAIT_UC: begin
        if (bus.uc_ended) begin
          if (bus.uc_found) begin
            next_state = S_CHECK;
          end else begin
            next_state  = S_FINISH;
            next_result = R_FIXPOINT;
          end
        end else if (wd_expired) begin
          next_state  = S_FINISH;
          next_result = R_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (lit_bad) begin
          next_state  = S_FINISH;
          next_result = R_BADLIT;
        end else if (var_assigned) begin
          // Re-applying an identical literal would loop forever.
          next_state  = S_FINISH;
          next_result = (var_value == lit_value) ? R_REPEAT : R_CONFLICT;
        end else begin
          next_state = S_SIMP;
        end
      end
      S_SIMP: next_state = S_WAIT_SIMP;
      S_WAIT_SIMP: begin
        if (bus.simp_done) begin
          if (bus.simp_conflict) begin
            next_state  = S_FINISH;
            next_result = R_CONFLICT;
          end else begin
            next_state = S_FIND;
          end
        end else if (wd_expired) begin
          next_state  = S_FINISH;
          next_result = R_TIMEOUT;
        end
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase

    // Abort beats every other transition. FINISH is excluded because the
    // run has already ended there.
    if (abort && (state != S_IDLE) && (state != S_FINISH)) begin
      next_state  = S_FINISH;
      next_result = R_ABORT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= R_FIXPOINT;
      prop_count     <= '0;
      assign_set     <= '0;
      assign_val     <= '0;
      watchdog       <= '0;
      lit_q          <= '0;
      bus.uc_find    <= 1'b0;
      bus.simp_start <= 1'b0;
      bus.simp_lit   <= '0;
    end else begin
      state          <= next_state;
      busy           <= (next_state != S_IDLE);
      done           <= (next_state == S_FINISH);
      bus.uc_find    <= (next_state == S_FIND);
      bus.simp_start <= (next_state == S_SIMP);

      if (next_state == S_FINISH) result <= next_result;

      if (next_state == S_SIMP) bus.simp_lit <= lit_q;

      if ((state == S_WAIT_UC) && bus.uc_ended) lit_q <= bus.uc_lit;

      if ((state == S_FIND) || (state == S_SIMP)) begin
        watchdog <= '0;
      end else if ((state == S_WAIT_UC) || (state == S_WAIT_SIMP)) begin
        watchdog <= watchdog + 1'b1;
      end

      if ((state == S_IDLE) && start) begin
        prop_count <= '0;
      end else if (apply_lit && (prop_count != {CNT_W{1'b1}})) begin
        prop_count <= prop_count + 1'b1;
      end

      if ((state == S_IDLE) && !start && clear_map) begin
        assign_set <= '0;
        assign_val <= '0;
      end else if (apply_lit) begin
        assign_set <= assign_set | var_mask;
        if (lit_value) assign_val <= assign_val | var_mask;
        else           assign_val <= assign_val & ~var_mask;
      end
    end
  end

endmodule

// File: tb/tb_unit_prop_ctrl.sv
// tb_unit_prop_ctrl
//  Directed bench for unit_prop_ctrl with TIMEOUT = 16. The bench plays the
//  finder and simplifier by hand, stepping on falling edges: inputs change
//  and outputs are sampled at the falling edge, the DUT acts on the rising edge.
module tb_unit_prop_ctrl;

  localparam int NUM_VARS = 16;
  localparam int LIT_W    = 6;
  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 16;
  localparam int LIMIT    = 200;

  logic                clock;
  logic                reset;
  logic                start;
  logic                abort;
  logic                clear_map;
  logic                busy;
  logic                done;
  logic [2:0]          result;
  logic [CNT_W-1:0]    prop_count;
  logic [NUM_VARS-1:0] assign_set;
  logic [NUM_VARS-1:0] assign_val;
  logic [2:0]          fsm_state;

  unit_prop_if #(.LIT_W(LIT_W)) bus ();

  unit_prop_ctrl #(
    .NUM_VARS(NUM_VARS), .LIT_W(LIT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .clear_map(clear_map), .busy(busy), .done(done), .result(result),
    .prop_count(prop_count), .assign_set(assign_set),
    .assign_val(assign_val), .fsm_state(fsm_state), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests    = 0;
  int fails    = 0;
  int simp_cnt = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge clock) if (bus.simp_start) simp_cnt <= simp_cnt + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return bus.uc_find;
      1:       return bus.simp_start;
      default: return done;
    endcase
  endfunction

  // Bounded wait for an output; reports cycles spent waiting.
  task automatic wait_for(input int which, input string tag, output int cycles);
    cycles = 0;
    while (!sig(which) && cycles < LIMIT) begin
      step();
      cycles++;
    end
    check(tag, 32'(sig(which)), 32'd1);
  endtask

  // ---------------- driver tasks ----------------
  // Called in IDLE; returns at the falling edge of the uc_find cycle.
  task automatic start_run(input string tag);
    int c;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_for(0, tag, c);
    check({tag, "_lat"}, 32'(c), 32'd0);
  endtask

  // Called in the uc_find cycle; answers in the first WAIT_UC cycle.
  task automatic finder_reply(input logic found, input logic [LIT_W-1:0] lit);
    step();
    bus.uc_ended = 1'b1;
    bus.uc_found = found;
    bus.uc_lit   = lit;
    step();
    bus.uc_ended = 1'b0;
    bus.uc_found = 1'b0;
    bus.uc_lit   = '0;
  endtask

  // Called in the simp_start cycle; answers in the first WAIT_SIMP cycle.
  task automatic simp_reply(input logic conflict);
    step();
    bus.simp_done     = 1'b1;
    bus.simp_conflict = conflict;
    step();
    bus.simp_done     = 1'b0;
    bus.simp_conflict = 1'b0;
  endtask

  task automatic to_idle(input string tag);
    step();
    check(tag, {30'd0, busy, done}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    abort             = 1'b0;
    clear_map         = 1'b0;
    bus.uc_ended      = 1'b0;
    bus.uc_found      = 1'b0;
    bus.uc_lit        = '0;
    bus.simp_done     = 1'b0;
    bus.simp_conflict = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_result",  32'(result), 32'd0);
    check("rst_count",   32'(prop_count), 32'd0);
    check("rst_set",     32'(assign_set), 32'd0);
    check("rst_val",     32'(assign_val), 32'd0);
    check("rst_find",    32'(bus.uc_find), 32'd0);
    check("rst_sstart",  32'(bus.simp_start), 32'd0);
    check("rst_slit",    32'(bus.simp_lit), 32'd0);
    check("rst_state",   32'(fsm_state), 32'd0);

    // T1: immediate fixpoint
    start_run("t1_find");
    check("t1_busy", 32'(busy), 32'd1);
    finder_reply(1'b0, '0);
    wait_for(2, "t1_done", cyc);
    check("t1_done_lat", 32'(cyc), 32'd0);
    check("t1_result", 32'(result), 32'd0);
    check("t1_count",  32'(prop_count), 32'd0);
    check("t1_set",    32'(assign_set), 32'd0);
    to_idle("t1_idle");

    // T2: +3, -5, then fixpoint
    start_run("t2_find1");
    finder_reply(1'b1, 6'h03);
    wait_for(1, "t2_sstart1", cyc);
    check("t2_sstart1_lat", 32'(cyc), 32'd1);
    check("t2_slit1", 32'(bus.simp_lit), 32'h03);
    simp_reply(1'b0);
    wait_for(0, "t2_find2", cyc);
    check("t2_find2_lat", 32'(cyc), 32'd0);
    finder_reply(1'b1, 6'h25);
    wait_for(1, "t2_sstart2", cyc);
    check("t2_slit2", 32'(bus.simp_lit), 32'h25);
    simp_reply(1'b0);
    wait_for(0, "t2_find3", cyc);
    finder_reply(1'b0, '0);
    wait_for(2, "t2_done", cyc);
    check("t2_result", 32'(result), 32'd0);
    check("t2_count",  32'(prop_count), 32'd2);
    check("t2_set",    32'(assign_set), 32'h0014);
    check("t2_val",    32'(assign_val), 32'h0004);
    to_idle("t2_idle");

    // T3: -3 against var3 = true -> conflict, no simplifier request
    base = simp_cnt;
    start_run("t3_find");
    finder_reply(1'b1, 6'h23);
    wait_for(2, "t3_done", cyc);
    check("t3_done_lat", 32'(cyc), 32'd1);
    check("t3_result", 32'(result), 32'd1);
    check("t3_nosimp", 32'(simp_cnt - base), 32'd0);
    check("t3_count",  32'(prop_count), 32'd0);
    to_idle("t3_idle");

    // REPEAT: +5 is unassigned? no: var5 = false, so -5 repeats
    start_run("rep_find");
    finder_reply(1'b1, 6'h25);
    wait_for(2, "rep_done", cyc);
    check("rep_result", 32'(result), 32'd2);
    to_idle("rep_idle");

    // T4: +7 then simplifier conflict
    start_run("t4_find");
    finder_reply(1'b1, 6'h07);
    wait_for(1, "t4_sstart", cyc);
    simp_reply(1'b1);
    wait_for(2, "t4_done", cyc);
    check("t4_done_lat", 32'(cyc), 32'd0);
    check("t4_result", 32'(result), 32'd1);
    check("t4_set",    32'(assign_set), 32'h0054);
    check("t4_val",    32'(assign_val), 32'h0044);
    check("t4_count",  32'(prop_count), 32'd1);
    to_idle("t4_idle");

    // clear_map in IDLE
    clear_map = 1'b1;
    step();
    clear_map = 1'b0;
    check("clr_set", 32'(assign_set), 32'd0);
    check("clr_val", 32'(assign_val), 32'd0);

    // T5a: silent finder -> timeout 17 cycles after the uc_find cycle
    start_run("t5_find");
    wait_for(2, "t5_done", cyc);
    check("t5_done_lat", 32'(cyc), 32'(TIMEOUT + 1));
    check("t5_result", 32'(result), 32'd3);
    to_idle("t5_idle");

    // T5b: abort in WAIT_SIMP together with simp_done
    start_run("t5b_find");
    finder_reply(1'b1, 6'h01);
    wait_for(1, "t5b_sstart", cyc);
    step();
    abort         = 1'b1;
    bus.simp_done = 1'b1;
    step();
    abort         = 1'b0;
    bus.simp_done = 1'b0;
    wait_for(2, "t5b_done", cyc);
    check("t5b_done_lat", 32'(cyc), 32'd0);
    check("t5b_result", 32'(result), 32'd4);
    check("t5b_set",    32'(assign_set), 32'h0001);
    check("t5b_val",    32'(assign_val), 32'h0001);
    to_idle("t5b_idle");
    bus.simp_done = 1'b1;
    step();
    bus.simp_done = 1'b0;
    check("t5b_late", {30'd0, busy, bus.uc_find}, 32'd0);

    // start with clear_map: start wins, map kept; then abort in FIND
    clear_map = 1'b1;
    start_run("sc_find");
    clear_map = 1'b0;
    check("sc_set", 32'(assign_set), 32'h0001);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_for(2, "sc_done", cyc);
    check("sc_result", 32'(result), 32'd4);
    to_idle("sc_idle");

    // T6: asynchronous reset in WAIT_SIMP
    start_run("t6_find");
    finder_reply(1'b1, 6'h02);
    wait_for(1, "t6_sstart", cyc);
    step();
    #2 reset = 1'b1;
    #1;
    check("t6_busy",   32'(busy), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    check("t6_count",  32'(prop_count), 32'd0);
    check("t6_set",    32'(assign_set), 32'd0);
    check("t6_slit",   32'(bus.simp_lit), 32'd0);
    check("t6_state",  32'(fsm_state), 32'd0);
    step();
    reset = 1'b0;
    step();

    // BADLIT: index 0, then index 17
    start_run("bad0_find");
    finder_reply(1'b1, 6'h00);
    wait_for(2, "bad0_done", cyc);
    check("bad0_lat", 32'(cyc), 32'd1);
    check("bad0_result", 32'(result), 32'd5);
    to_idle("bad0_idle");
    start_run("bad17_find");
    finder_reply(1'b1, 6'h11);
    wait_for(2, "bad17_done", cyc);
    check("bad17_result", 32'(result), 32'd5);
    check("bad17_set", 32'(assign_set), 32'd0);
    to_idle("bad17_idle");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
